// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: resolves traps, memory waits, mul/div waits,
// branch redirects, load-use hazards and fetch stalls into PC and
// pipeline-register enable/flush controls, and keeps stall/flush statistics.
module pipe_ctrl #(
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DRAIN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [AW-1:0]    ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             md_start,
    input  logic             md_done,
    input  logic             mem_busy,
    input  logic             imem_busy,
    input  logic             trap_req,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             en_fd,
    output logic             en_de,
    output logic             en_em,
    output logic             en_mw,
    output logic             fl_fd,
    output logic             fl_de,
    output logic             fl_em,
    output logic             fl_mw,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [15:0]      flush_cnt
);

    localparam int unsigned DW = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MDIV  = 2'd1,
        ST_MEMW  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [CNT_W-1:0]  stall_q;
    logic [15:0]       flush_q;
    logic              flush_ev;
    logic              load_use;

    // Load-use hazard: ID reads the register a load in EX has not produced yet
    assign load_use = ex_is_load && (ex_rd != '0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    // State and drain-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Next state and prioritised pipeline controls (highest condition wins)
    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        pc_en    = 1'b1;
        pc_sel   = 2'd0;
        en_fd    = 1'b1;
        en_de    = 1'b1;
        en_em    = 1'b1;
        en_mw    = 1'b1;
        fl_fd    = 1'b0;
        fl_de    = 1'b0;
        fl_em    = 1'b0;
        fl_mw    = 1'b0;
        flush_ev = 1'b0;

        if (trap_req) begin
            pc_sel   = 2'd2;
            fl_fd    = 1'b1;
            fl_de    = 1'b1;
            fl_em    = 1'b1;
            fl_mw    = 1'b1;
            flush_ev = 1'b1;
            state_d  = ST_DRAIN;
            drain_d  = DW'(DRAIN);
        end else if (state_q == ST_DRAIN) begin
            pc_en = 1'b0;
            fl_fd = 1'b1;
            fl_de = 1'b1;
            fl_em = 1'b1;
            fl_mw = 1'b1;
            if (drain_q <= DW'(1)) begin
                state_d = ST_RUN;
                drain_d = '0;
            end else begin
                drain_d = drain_q - DW'(1);
            end
        end else if (mem_busy) begin
            pc_en   = 1'b0;
            en_fd   = 1'b0;
            en_de   = 1'b0;
            en_em   = 1'b0;
            fl_mw   = 1'b1;
            state_d = ST_MEMW;
        end else if ((state_q == ST_MDIV) && !md_done) begin
            pc_en = 1'b0;
            en_fd = 1'b0;
            en_de = 1'b0;
            fl_em = 1'b1;
        end else begin
            // RUN rules; also the exit cycle of MEMW and MDIV
            state_d = ST_RUN;
            if ((state_q == ST_RUN) && md_start) begin
                state_d = ST_MDIV;
            end
            if (ex_redirect) begin
                pc_sel   = 2'd1;
                fl_fd    = 1'b1;
                fl_de    = 1'b1;
                flush_ev = 1'b1;
            end else if (load_use) begin
                pc_en = 1'b0;
                en_fd = 1'b0;
                fl_de = 1'b1;
            end else if (imem_busy) begin
                pc_en = 1'b0;
                fl_fd = 1'b1;
            end
        end

        // Reset forces a full bubble load with the PC held
        if (rst) begin
            pc_en    = 1'b0;
            pc_sel   = 2'd0;
            en_fd    = 1'b1;
            en_de    = 1'b1;
            en_em    = 1'b1;
            en_mw    = 1'b1;
            fl_fd    = 1'b1;
            fl_de    = 1'b1;
            fl_em    = 1'b1;
            fl_mw    = 1'b1;
            flush_ev = 1'b0;
        end
    end

    // Wrapping statistics counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_ev) begin
                flush_q <= flush_q + 16'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule
